// File: rtl/madd_err_accum_if.sv
`default_nettype none
// ============================================================================
//  Module   : madd_err_accum_if
//  Purpose  : Control, sample-handshake and metric bundle between a stimulus
//             source (master) and the error accumulator (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface madd_err_accum_if #(
    parameter int W = 6
) ();

    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] approx;
    logic [W-1:0] exact;
    logic         busy;
    logic         done;
    logic [9:0]   err_count;
    logic [15:0]  sum_abs_err;
    logic [15:0]  sum_err;
    logic [W-1:0] max_abs_err;

    // Stimulus side: drives the run control and sample pairs
    modport master (
        output start,
        output in_valid,
        output approx,
        output exact,
        input  in_ready,
        input  busy,
        input  done,
        input  err_count,
        input  sum_abs_err,
        input  sum_err,
        input  max_abs_err
    );

    // Accumulator side: consumes pairs, reports status and metrics
    modport slave (
        input  start,
        input  in_valid,
        input  approx,
        input  exact,
        output in_ready,
        output busy,
        output done,
        output err_count,
        output sum_abs_err,
        output sum_err,
        output max_abs_err
    );

endinterface
`default_nettype wire

// File: rtl/madd_err_accum.sv
`default_nettype none
// ============================================================================
//  Module   : madd_err_accum
//  Purpose  : Accumulates error metrics of an approximate adder against its
//             exact reference over a run of N_SAMPLES accepted pairs:
//             mismatch count, sum of |d|, signed sum of d and max |d|.
//  Revision : 1.0  initial release
// ============================================================================
module madd_err_accum #(
    parameter int N_SAMPLES = 512,
    parameter int W         = 6
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    madd_err_accum_if.slave   bus
);

    // Counter value at which the accepted pair is the final one of the run
    localparam logic [9:0] C_LAST = 10'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    logic         in_ready_q;
    logic         busy_q;
    logic         done_q;
    logic [9:0]   cnt_q;
    logic [9:0]   err_count_q;
    logic [15:0]  sum_abs_q;
    logic [15:0]  sum_err_q;
    logic [W-1:0] max_abs_q;

    logic         accept;
    logic [W:0]   diff;
    logic [W-1:0] abs_d;
    logic [9:0]   cnt_d;
    logic [9:0]   err_count_d;
    logic [15:0]  sum_abs_d;
    logic [15:0]  sum_err_d;
    logic [W-1:0] max_abs_d;

    // A pair is taken only while the registered ready is high
    assign accept = bus.in_valid & in_ready_q;

    // Signed difference at W+1 bits; the magnitude is taken by subtracting in
    // the right order so it always fits W bits without a negate step
    assign diff  = {1'b0, bus.approx} - {1'b0, bus.exact};
    assign abs_d = diff[W] ? (bus.exact - bus.approx) : (bus.approx - bus.exact);

    // Candidate metric values if the current pair is accepted
    assign cnt_d       = cnt_q + 10'd1;
    assign err_count_d = err_count_q + {9'd0, (diff != '0)};
    assign sum_abs_d   = sum_abs_q + {{(16 - W){1'b0}}, abs_d};
    assign sum_err_d   = sum_err_q + {{(15 - W){diff[W]}}, diff};
    assign max_abs_d   = (abs_d > max_abs_q) ? abs_d : max_abs_q;

    // Run-control FSM with registered status flags and metric accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            err_count_q <= '0;
            sum_abs_q   <= '0;
            sum_err_q   <= '0;
            max_abs_q   <= '0;
        end else begin
            case (state_q)
                // Both idle and finished states restart straight into RUN
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q     <= RUN;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        cnt_q       <= '0;
                        err_count_q <= '0;
                        sum_abs_q   <= '0;
                        sum_err_q   <= '0;
                        max_abs_q   <= '0;
                    end
                end

                // start is deliberately ignored here; only pairs matter
                RUN: begin
                    if (accept) begin
                        cnt_q       <= cnt_d;
                        err_count_q <= err_count_d;
                        sum_abs_q   <= sum_abs_d;
                        sum_err_q   <= sum_err_d;
                        max_abs_q   <= max_abs_d;
                        if (cnt_q == C_LAST) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_count   = err_count_q;
    assign bus.sum_abs_err = sum_abs_q;
    assign bus.sum_err     = sum_err_q;
    assign bus.max_abs_err = max_abs_q;

endmodule
`default_nettype wire

// File: tb/tb_madd_err_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_madd_err_accum
//  Purpose  : Self-checking bench for madd_err_accum. Two instances (runs of
//             4 and 512 samples) are compared every cycle against a model
//             that keeps the list of accepted differences of the current run
//             and derives the metrics from that list.
//  Revision : 1.0  initial release
// ============================================================================
module tb_madd_err_accum;

    localparam int W      = 6;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    madd_err_accum_if #(.W(W)) b4 ();
    madd_err_accum_if #(.W(W)) b512 ();

    madd_err_accum #(.N_SAMPLES(4), .W(W)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    madd_err_accum #(.N_SAMPLES(512), .W(W)) u_dut512 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b512)
    );

    int total = 0;
    int bad   = 0;
    int mode [2];
    int q0 [$];
    int q1 [$];

    function automatic int nsamp(input int k);
        return (k == 0) ? 4 : 512;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int k, input logic s, input logic v,
                          input logic [W-1:0] a, input logic [W-1:0] e);
        if (k == 0) begin
            b4.start = s; b4.in_valid = v; b4.approx = a; b4.exact = e;
        end else begin
            b512.start = s; b512.in_valid = v; b512.approx = a; b512.exact = e;
        end
    endtask

    task automatic model_reset();
        mode[0] = M_IDLE;
        mode[1] = M_IDLE;
        q0.delete();
        q1.delete();
    endtask

    // What happens at the coming rising edge, from the spec's rules
    task automatic model_edge();
        logic s, v;
        int   d;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                s = b4.start; v = b4.in_valid; d = int'(b4.approx) - int'(b4.exact);
            end else begin
                s = b512.start; v = b512.in_valid; d = int'(b512.approx) - int'(b512.exact);
            end
            if (mode[k] != M_RUN && s) begin
                mode[k] = M_RUN;
                if (k == 0) q0.delete(); else q1.delete();
            end else if (mode[k] == M_RUN && v) begin
                if (k == 0) begin
                    q0.push_back(d);
                    if (q0.size() == nsamp(0)) mode[0] = M_DONE;
                end else begin
                    q1.push_back(d);
                    if (q1.size() == nsamp(1)) mode[1] = M_DONE;
                end
            end
        end
    endtask

    task automatic exp_metrics(input int k, output int ec, output int sa,
                               output int se, output int mx);
        int d, a, n;
        ec = 0; sa = 0; se = 0; mx = 0;
        n = (k == 0) ? q0.size() : q1.size();
        for (int i = 0; i < n; i++) begin
            d  = (k == 0) ? q0[i] : q1[i];
            a  = (d < 0) ? -d : d;
            ec += (d != 0) ? 1 : 0;
            sa += a;
            se += d;
            if (a > mx) mx = a;
        end
    endtask

    task automatic check_inst(input int k, input string tag);
        int ec, sa, se, mx;
        logic rdy, bsy, dn;
        logic [9:0] oec;
        logic [15:0] osa, ose;
        logic [W-1:0] omx;
        if (k == 0) begin
            rdy = b4.in_ready; bsy = b4.busy; dn = b4.done; oec = b4.err_count;
            osa = b4.sum_abs_err; ose = b4.sum_err; omx = b4.max_abs_err;
        end else begin
            rdy = b512.in_ready; bsy = b512.busy; dn = b512.done; oec = b512.err_count;
            osa = b512.sum_abs_err; ose = b512.sum_err; omx = b512.max_abs_err;
        end
        exp_metrics(k, ec, sa, se, mx);
        chk({tag, "_ready"}, 32'(rdy), 32'(mode[k] == M_RUN));
        chk({tag, "_busy"},  32'(bsy), 32'(mode[k] == M_RUN));
        chk({tag, "_done"},  32'(dn),  32'(mode[k] == M_DONE));
        chk({tag, "_errcnt"}, 32'(oec), ec);
        chk({tag, "_sumabs"}, 32'(osa), sa);
        chk({tag, "_sumerr"}, 32'($signed(ose)), se);
        chk({tag, "_maxabs"}, 32'(omx), mx);
    endtask

    task automatic check_all(input string tag);
        check_inst(0, {tag, "_n4"});
        check_inst(1, {tag, "_n512"});
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int busy_cnt;
        int guard;
        logic [W-1:0] ra, re;

        rst_n = 1'b0;
        set_in(0, 1'b0, 1'b0, '0, '0);
        set_in(1, 1'b0, 1'b0, '0, '0);
        model_reset();

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        tick("idle");

        // Four directed pairs on the short run
        set_in(0, 1'b1, 1'b0, '0, '0);
        tick("a_start");
        set_in(0, 1'b0, 1'b1, 6'd5, 6'd5);   tick("a_p0");
        set_in(0, 1'b0, 1'b1, 6'd7, 6'd4);   tick("a_p1");
        set_in(0, 1'b0, 1'b1, 6'd2, 6'd6);   tick("a_p2");
        set_in(0, 1'b0, 1'b1, 6'd63, 6'd0);  tick("a_p3");
        chk("a_done",   32'(b4.done), 1);
        chk("a_errcnt", 32'(b4.err_count), 3);
        chk("a_sumabs", 32'(b4.sum_abs_err), 70);
        chk("a_sumerr", 32'(b4.sum_err), 32'h003E);
        chk("a_maxabs", 32'(b4.max_abs_err), 63);

        // DONE holds metrics against arbitrary valid traffic, then restarts
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1'b0, 1'b1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
            tick("b_hold");
        end
        chk("b_hold_sumabs", 32'(b4.sum_abs_err), 70);
        set_in(0, 1'b1, 1'b0, '0, '0);
        tick("b_restart");
        chk("b_restart_busy",   32'(b4.busy), 1);
        chk("b_restart_sumabs", 32'(b4.sum_abs_err), 0);
        chk("b_restart_errcnt", 32'(b4.err_count), 0);

        // Toggling valid with start pulses during RUN
        for (int i = 0; i < 7; i++) begin
            set_in(0, (i == 1 || i == 2 || i == 3 || i == 5), (i % 2 == 0), 6'd3, 6'd1);
            tick("c_tog");
        end
        chk("c_done",   32'(b4.done), 1);
        chk("c_sumabs", 32'(b4.sum_abs_err), 8);

        // Reset mid-run discards partial metrics immediately
        set_in(0, 1'b1, 1'b0, '0, '0);
        tick("d_start");
        set_in(0, 1'b0, 1'b1, 6'd9, 6'd1);
        tick("d_p0");
        tick("d_p1");
        set_in(0, 1'b0, 1'b0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("d_async");
        tick("d_held");
        rst_n = 1'b1;
        tick("d_released");
        set_in(0, 1'b1, 1'b0, '0, '0);
        tick("d_restart");
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1'b0, 1'b1, 6'd1, 6'd1);
            tick("d_eq");
        end
        chk("d_done",   32'(b4.done), 1);
        chk("d_errcnt", 32'(b4.err_count), 0);
        set_in(0, 1'b0, 1'b0, '0, '0);

        // Full run of matching pairs; busy length
        set_in(1, 1'b1, 1'b0, '0, '0);
        tick("e_start");
        busy_cnt = b512.busy ? 1 : 0;
        for (int i = 0; i < 520; i++) begin
            ra = 6'($urandom_range(0, 63));
            set_in(1, 1'b0, 1'b1, ra, ra);
            tick("e_eq");
            if (b512.busy) busy_cnt++;
        end
        chk("e_busy_cycles", busy_cnt, 512);
        chk("e_done",   32'(b512.done), 1);
        chk("e_errcnt", 32'(b512.err_count), 0);

        // Worst-case negative error on every pair
        set_in(1, 1'b1, 1'b0, '0, '0);
        tick("f_start");
        for (int i = 0; i < 512; i++) begin
            set_in(1, 1'b0, 1'b1, 6'd0, 6'd63);
            tick("f_worst");
        end
        chk("f_done",    32'(b512.done), 1);
        chk("f_errcnt",  32'(b512.err_count), 512);
        chk("f_sumabs",  32'(b512.sum_abs_err), 32256);
        chk("f_sumerr",  32'($signed(b512.sum_err)), -32256);
        chk("f_sumbits", 32'(b512.sum_err), 32'h8200);
        chk("f_maxabs",  32'(b512.max_abs_err), 63);

        // Random traffic with random start pulses until the run completes
        set_in(1, 1'b1, 1'b0, '0, '0);
        tick("g_start");
        guard = 0;
        while (mode[1] != M_DONE && guard < 3000) begin
            ra = 6'($urandom_range(0, 63));
            re = 6'($urandom_range(0, 63));
            set_in(1, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), ra, re);
            tick("g_rnd");
            guard++;
        end
        chk("g_finished_in_bound", 32'(guard < 3000), 1);
        chk("g_done", 32'(b512.done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/madd_err_accum.md
MADD_ERR_ACCUM -- requirements
Module: madd_err_accum

Interface
REQ-001 Parameter N_SAMPLES, default 512, number of samples per measurement run (2^9, exhaustive over the 9-bit operand space), legal range 1..512.
REQ-002 Parameter W, default 6, result width of the approximate and exact datapaths.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begins a new run; sampled in IDLE and DONE only.
REQ-006 in_valid  input  1  approx/exact pair present this cycle.
REQ-007 in_ready  output  1  block accepts a pair this cycle.
REQ-008 approx  input  W  approximate adder output, unsigned.
REQ-009 exact  input  W  golden result for the same operands, unsigned.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  high in DONE; metrics valid and stable.
REQ-012 err_count  output  10  number of accepted pairs with approx != exact.
REQ-013 sum_abs_err  output  16  sum of |approx - exact|, unsigned.
REQ-014 sum_err  output  16  sum of (approx - exact), two's complement signed.
REQ-015 max_abs_err  output  W  largest |approx - exact| seen.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE -> RUN when start=1; on that edge all four metrics and the sample counter clear to 0.
REQ-018 in_ready = 1 only in RUN; 0 in IDLE and DONE.
REQ-019 Accept a pair on a rising edge with in_valid=1 and in_ready=1; no acceptance otherwise, metrics hold.
REQ-020 Per accepted pair: d = approx - exact computed at W+1 bits signed; |d| range 0..2^W-1.
REQ-021 On the accepting edge: err_count += (d!=0); sum_abs_err += |d|; sum_err += d (sign-extended); max_abs_err = max(max_abs_err, |d|); sample counter += 1.
REQ-022 Metric latency: one clock; the value including a pair appears on the output the cycle after acceptance.
REQ-023 RUN -> DONE on the edge that accepts pair number N_SAMPLES; that pair is included in the final metrics.
REQ-024 start while in RUN is ignored; the run continues with no clearing.
REQ-025 DONE holds all metrics unchanged until start=1; DONE -> RUN on start, clearing as in REQ-017 (no intermediate IDLE cycle).
REQ-026 in_valid while in_ready=0 has no effect; pairs are not queued.
REQ-027 Arithmetic does not saturate; with N_SAMPLES<=512 and W=6 no accumulator overflows (max sum_abs_err 32256, |sum_err|<=32256).
REQ-028 busy and done are mutually exclusive; both 0 in IDLE.

Reset
REQ-029 rst_n=0 forces state IDLE, in_ready=0, busy=0, done=0, all metrics 0, sample counter 0, immediately and independent of clk.
REQ-030 Reset asserted mid-run aborts the run; partial metrics are discarded; a new start is required after release.
REQ-031 First acceptance possible no earlier than the second rising edge after rst_n deasserts (start edge, then first RUN edge).

Verification
REQ-032 N_SAMPLES=4; start; pairs (approx,exact) = (5,5),(7,4),(2,6),(63,0), in_valid=1 continuous -> done after 4th acceptance; err_count=3, sum_abs_err=70, sum_err=62 (0x003E), max_abs_err=63.
REQ-033 N_SAMPLES=512, all pairs approx==exact -> done after exactly 512 acceptances; all metrics 0; busy high for exactly 512 cycles with in_valid held 1.
REQ-034 N_SAMPLES=512, every pair (0,63) -> err_count=512, sum_abs_err=32256, sum_err=-32256 (0x8200), max_abs_err=63; no overflow.
REQ-035 N_SAMPLES=4, in_valid toggled 1,0,1,0,... with pair (3,1) -> only valid cycles counted; done after 4 valid cycles; sum_abs_err=8; start pulses during RUN ignored.
REQ-036 Reset asserted after 2 acceptances of (9,1) -> all outputs 0 in the same cycle, state IDLE; after release, start plus 4 pairs of (1,1) -> err_count=0.
REQ-037 In DONE, in_valid=1 with arbitrary data for 10 cycles -> metrics unchanged; then start -> metrics read 0 on the next cycle, busy=1.
